// File: rtl/nd_1ton_buf_if.sv
`default_nettype none
// ============================================================================
//  Module   : nd_1ton_buf_if
//  Brief    : Handshake bundle for the 1-to-N routing node. It carries one
//             receive channel and NUM_OUT send channels, each using a 4-phase
//             req/ack handshake.
//             slave  - node side (receives on rcv0, drives snd)
//             master - environment side (drives rcv0, sinks snd)
//  Revision : 1.0 - initial release
// ============================================================================
interface nd_1ton_buf_if #(
    parameter int MSZ     = 20,
    parameter int NUM_OUT = 4
);
    logic                     rcv0_req;
    logic [MSZ-1:0]           rcv0_dat;
    logic                     rcv0_ack;
    logic [NUM_OUT-1:0]       snd_req;
    logic [NUM_OUT*MSZ-1:0]   snd_dat;
    logic [NUM_OUT-1:0]       snd_ack;

    modport master (
        output rcv0_req,
        output rcv0_dat,
        input  rcv0_ack,
        input  snd_req,
        input  snd_dat,
        output snd_ack
    );

    modport slave (
        input  rcv0_req,
        input  rcv0_dat,
        output rcv0_ack,
        output snd_req,
        output snd_dat,
        input  snd_ack
    );
endinterface
`default_nettype wire

// File: rtl/nd_1ton_buf.sv
`default_nettype none
// ============================================================================
//  Module   : nd_1ton_buf
//  Brief    : A single receive channel fans out to NUM_OUT send channels.
//             The destination address is compared against an ascending list
//             of thresholds to choose the output. Each output has its own
//             FIFO, so a stalled sink only blocks the input once its own FIFO
//             has filled.
//  Options  : ND_1TON_RED_CHECK_EN - verifies the redundancy field on accept.
//             Messages that fail the check are acked but dropped, and err_cnt
//             counts them.
//  Revision : 1.0 - initial release
// ============================================================================
module nd_1ton_buf #(
    parameter int ASZ     = 6,
    parameter int DSZ     = 4,
    parameter int RSZ     = 4,
    parameter int NUM_OUT = 4,
    parameter int DEPTH   = 4,
    parameter logic [(NUM_OUT-1)*ASZ-1:0] REF_VALS = {6'd41, 6'd27, 6'd13}
) (
    input  wire logic     i_clk,
    input  wire logic     reset,
    output logic          ready,
    nd_1ton_buf_if.slave  bus,
    output logic [7:0]    err_cnt
);
    localparam int c_msz = 2*ASZ + DSZ + RSZ;
    localparam int c_psz = 2*ASZ + DSZ;
    localparam int c_pw  = $clog2(DEPTH);
    localparam int c_iw  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [c_pw:0]   c_depth   = (c_pw+1)'(DEPTH);
    localparam logic [c_pw:0]   c_cnt_one = (c_pw+1)'(1);
    localparam logic [c_pw-1:0] c_ptr_one = c_pw'(1);
    localparam logic [c_iw-1:0] c_idx_one = c_iw'(1);

    typedef enum logic [0:0] {
        RX_IDLE = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_t;

    logic                     r_ready;
    rx_state_t                r_rx_state;
    rx_state_t                w_rx_nxt;
    logic                     r_rcv_ack;
    logic                     w_ack_nxt;
    logic                     w_accept;
    logic                     w_write;
    logic                     w_red_ok;
    logic [ASZ-1:0]           w_dst;
    logic [c_iw-1:0]          w_idx;
    logic [NUM_OUT-1:0]       w_full_vec;
    logic [NUM_OUT-1:0]       w_snd_req;
    logic [NUM_OUT*c_msz-1:0] w_snd_dat;

    assign w_dst        = bus.rcv0_dat[RSZ+DSZ +: ASZ];
    assign ready        = r_ready;
    assign bus.rcv0_ack = r_rcv_ack;
    assign bus.snd_req  = w_snd_req;
    assign bus.snd_dat  = w_snd_dat;

    // The node is ready from the first clock edge after reset releases.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) r_ready <= 1'b0;
        else        r_ready <= 1'b1;
    end

    // Route index: the number of thresholds the destination strictly exceeds.
    always_comb begin
        w_idx = '0;
        for (int k = 0; k < NUM_OUT-1; k++) begin
            if (w_dst > REF_VALS[k*ASZ +: ASZ]) w_idx = w_idx + c_idx_one;
        end
    end

`ifdef ND_1TON_RED_CHECK_EN
    logic [c_psz-1:0] w_payload;
    logic [RSZ-1:0]   w_red;
    logic [RSZ-1:0]   w_red_calc;
    logic [7:0]       r_err_cnt;

    assign w_payload = bus.rcv0_dat[c_msz-1:RSZ];
    assign w_red     = bus.rcv0_dat[RSZ-1:0];

    // Redundancy bit i is the XOR of payload bits whose index is i mod RSZ.
    always_comb begin
        w_red_calc = '0;
        for (int i = 0; i < RSZ; i++) begin
            for (int j = 0; j < c_psz; j++) begin
                if ((j % RSZ) == i) w_red_calc[i] = w_red_calc[i] ^ w_payload[j];
            end
        end
    end

    assign w_red_ok = (w_red_calc == w_red);

    // Count dropped messages, saturating at the top of the range.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset)
            r_err_cnt <= 8'd0;
        else if (w_accept && !w_red_ok && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_cnt = r_err_cnt;
`else
    assign w_red_ok = 1'b1;
    assign err_cnt  = 8'd0;
`endif

    // A corrupted message is still acked, but it does not reach any FIFO.
    assign w_write = w_accept && w_red_ok;

    // Input FSM state and ack register.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            r_rx_state <= RX_IDLE;
            r_rcv_ack  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_nxt;
            r_rcv_ack  <= w_ack_nxt;
        end
    end

    // Input FSM next state. A full target FIFO holds the message at the head
    // of the line, whether or not its redundancy check would pass.
    always_comb begin
        w_rx_nxt  = r_rx_state;
        w_ack_nxt = r_rcv_ack;
        w_accept  = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_ready && bus.rcv0_req && !w_full_vec[w_idx]) begin
                    w_accept  = 1'b1;
                    w_ack_nxt = 1'b1;
                    w_rx_nxt  = RX_ACK;
                end
            end
            RX_ACK: begin
                if (!bus.rcv0_req) begin
                    w_ack_nxt = 1'b0;
                    w_rx_nxt  = RX_IDLE;
                end
            end
            default: begin
                w_ack_nxt = 1'b0;
                w_rx_nxt  = RX_IDLE;
            end
        endcase
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        logic [c_msz-1:0] r_mem [DEPTH];
        logic [c_pw-1:0]  r_wptr;
        logic [c_pw-1:0]  r_rptr;
        logic [c_pw:0]    r_cnt;
        tx_state_t        r_tx_state;
        tx_state_t        w_tx_nxt;
        logic             r_req;
        logic             w_req_nxt;
        logic [c_msz-1:0] r_dat;
        logic             w_load;
        logic             w_pop;
        logic             w_push;
        logic             w_empty;

        assign w_push        = w_write && (w_idx == c_iw'(k));
        assign w_empty       = (r_cnt == '0);
        assign w_full_vec[k] = (r_cnt == c_depth);
        assign w_snd_req[k]  = r_req;
        assign w_snd_dat[k*c_msz +: c_msz] = r_dat;

        // FIFO storage. Writes land at the write pointer and are never
        // forwarded to the output in the same cycle.
        always_ff @(posedge i_clk) begin
            if (w_push) r_mem[r_wptr] <= bus.rcv0_dat;
        end

        // FIFO pointers and occupancy. Push and pop may happen in the same cycle.
        always_ff @(posedge i_clk or negedge reset) begin
            if (!reset) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + c_ptr_one;
                if (w_pop)  r_rptr <= r_rptr + c_ptr_one;
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + c_cnt_one;
                    2'b01:   r_cnt <= r_cnt - c_cnt_one;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        // Output FSM state, request and data registers. Data holds while idle.
        always_ff @(posedge i_clk or negedge reset) begin
            if (!reset) begin
                r_tx_state <= TX_IDLE;
                r_req      <= 1'b0;
                r_dat      <= '0;
            end else begin
                r_tx_state <= w_tx_nxt;
                r_req      <= w_req_nxt;
                if (w_load) r_dat <= r_mem[r_rptr];
            end
        end

        // Output FSM next state. The head entry leaves the FIFO only once the
        // sink has acknowledged it.
        always_comb begin
            w_tx_nxt  = r_tx_state;
            w_req_nxt = r_req;
            w_load    = 1'b0;
            w_pop     = 1'b0;
            case (r_tx_state)
                TX_IDLE: begin
                    if (!w_empty && !bus.snd_ack[k]) begin
                        w_load    = 1'b1;
                        w_req_nxt = 1'b1;
                        w_tx_nxt  = TX_REQ;
                    end
                end
                TX_REQ: begin
                    if (bus.snd_ack[k]) begin
                        w_req_nxt = 1'b0;
                        w_pop     = 1'b1;
                        w_tx_nxt  = TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (!bus.snd_ack[k]) w_tx_nxt = TX_IDLE;
                end
                default: begin
                    w_req_nxt = 1'b0;
                    w_tx_nxt  = TX_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_nd_1ton_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nd_1ton_buf
//  Brief    : Scoreboard bench for nd_1ton_buf with default parameters.
//             The source takes messages from tx_q. Expected messages go into
//             per-channel queues, and the sink monitors pop and compare them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nd_1ton_buf;
    localparam int NOUT = 4;
    localparam int MSZ  = 20;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ready;
    logic [7:0] err_cnt;

    nd_1ton_buf_if #(.MSZ(MSZ), .NUM_OUT(NOUT)) bus ();

    nd_1ton_buf #(
        .ASZ(6), .DSZ(4), .RSZ(4), .NUM_OUT(NOUT), .DEPTH(4),
        .REF_VALS({6'd41, 6'd27, 6'd13})
    ) dut (
        .i_clk   (clk),
        .reset   (rst_n),
        .ready   (ready),
        .bus     (bus),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [MSZ-1:0]   tx_q [$];
    logic [MSZ-1:0]   exp_q [NOUT][$];
    int               deliv [NOUT];
    int               acked = 0;
    logic [NOUT-1:0]  hold  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Build a message {src,dst,dat,red} with a correct redundancy field.
    function automatic logic [MSZ-1:0] mk(input int src, input int dst, input int dat);
        logic [15:0] p;
        logic [3:0]  r;
        p = {6'(src), 6'(dst), 4'(dat)};
        r = '0;
        for (int j = 0; j < 16; j++) r[j % 4] = r[j % 4] ^ p[j];
        return {p, r};
    endfunction

    task automatic send(input int src, input int dst, input int dat, input int ch);
        logic [MSZ-1:0] m;
        m = mk(src, dst, dat);
        tx_q.push_back(m);
        exp_q[ch].push_back(m);
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < NOUT; k++) if (exp_q[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input string name, input int limit);
        int c;
        c = 0;
        while (!(tx_q.size() == 0 && !bus.rcv0_req && !bus.rcv0_ack &&
                 bus.snd_req == '0 && bus.snd_ack == '0 && all_empty()) && c < limit) begin
            @(negedge clk);
            c++;
        end
        check({name, " drain in time"}, 64'(c < limit), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // Source: 4-phase sender fed from tx_q.
    initial begin
        bus.rcv0_req = 1'b0;
        bus.rcv0_dat = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) bus.rcv0_req = 1'b0;
            else if (bus.rcv0_req && bus.rcv0_ack) begin
                bus.rcv0_req = 1'b0;
                acked++;
            end else if (!bus.rcv0_req && !bus.rcv0_ack && tx_q.size() > 0) begin
                bus.rcv0_dat = tx_q.pop_front();
                bus.rcv0_req = 1'b1;
            end
        end
    end

    // Sinks and monitor: each new request is checked against the channel's queue.
    initial begin
        logic [MSZ-1:0] got;
        bus.snd_ack = '0;
        for (int k = 0; k < NOUT; k++) deliv[k] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NOUT; k++) begin
                if (!rst_n) bus.snd_ack[k] = 1'b0;
                else if (bus.snd_req[k] && !bus.snd_ack[k] && !hold[k]) begin
                    got = bus.snd_dat[k*MSZ +: MSZ];
                    if (exp_q[k].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL ch%0d unexpected msg: got %h expected none", k, got);
                    end else begin
                        check($sformatf("ch%0d data", k), 64'(got), 64'(exp_q[k].pop_front()));
                    end
                    deliv[k]++;
                    bus.snd_ack[k] = 1'b1;
                end else if (!bus.snd_req[k] && bus.snd_ack[k]) begin
                    bus.snd_ack[k] = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int base_ack;
        int base_d [NOUT];
        int c;
        int bdst [6];
        int bch  [6];
        logic [MSZ-1:0] m;

        bdst = '{13, 14, 27, 28, 41, 42};
        bch  = '{0, 1, 1, 2, 2, 3};

        // Outputs while held in reset.
        repeat (3) @(negedge clk);
        check("reset ready",    64'(ready),        64'd0);
        check("reset rcv0_ack", 64'(bus.rcv0_ack), 64'd0);
        check("reset snd_req",  64'(bus.snd_req),  64'd0);
        check("reset snd_dat",  64'(bus.snd_dat),  64'd0);
        check("reset err_cnt",  64'(err_cnt),      64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("ready after release", 64'(ready), 64'd1);

        // One message to each output.
        base_ack = acked;
        send(1, 5, 1, 0);
        send(2, 20, 2, 1);
        send(3, 30, 3, 2);
        send(4, 50, 4, 3);
        drain("basic", 400);
        check("basic acks", 64'(acked - base_ack), 64'd4);

        // Threshold boundaries.
        for (int i = 0; i < 6; i++) send(i + 8, bdst[i], i + 5, bch[i]);
        drain("boundary", 600);

        // Stall channel 1 until its FIFO fills, which blocks the input.
        base_ack = acked;
        for (int k = 0; k < NOUT; k++) base_d[k] = deliv[k];
        hold[1] = 1'b1;
        for (int i = 0; i < 5; i++) send(9, 20, i + 1, 1);
        send(10, 50, 7, 3);
        repeat (40) @(negedge clk);
        check("stall acks",        64'(acked - base_ack),     64'd4);
        check("stall rcv0_ack",    64'(bus.rcv0_ack),         64'd0);
        check("stall rcv0_req",    64'(bus.rcv0_req),         64'd1);
        check("stall snd_req1",    64'(bus.snd_req[1]),       64'd1);
        check("stall ch3 blocked", 64'(deliv[3] - base_d[3]), 64'd0);
        hold[1] = 1'b0;
        drain("stall release", 600);
        check("stall total acks",  64'(acked - base_ack),     64'd6);
        check("stall ch1 count",   64'(deliv[1] - base_d[1]), 64'd5);

        // Continuous stream to channel 0, wrapping the pointers several times.
        base_d[0] = deliv[0];
        for (int i = 0; i < 20; i++) send(i, 5, i % 16, 0);
        drain("stream", 1500);
        check("stream count", 64'(deliv[0] - base_d[0]), 64'd20);

        // Asynchronous reset while channel 2 is requesting and its FIFO is occupied.
        base_ack = acked;
        hold[2] = 1'b1;
        for (int i = 0; i < 3; i++) send(20 + i, 30, i, 2);
        c = 0;
        while (acked < base_ack + 3 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("rst fill in time", 64'(c < 100), 64'd1);
        repeat (4) @(negedge clk);
        check("rst pre snd_req2", 64'(bus.snd_req[2]), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async rst snd_req",  64'(bus.snd_req),  64'd0);
        check("async rst rcv0_ack", 64'(bus.rcv0_ack), 64'd0);
        check("async rst ready",    64'(ready),        64'd0);
        check("async rst snd_dat",  64'(bus.snd_dat),  64'd0);
        exp_q[2].delete();
        hold[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("ready after async rst", 64'(ready), 64'd1);
        base_d[2] = deliv[2];
        send(33, 30, 9, 2);
        drain("post reset", 400);
        check("post reset ch2 count", 64'(deliv[2] - base_d[2]), 64'd1);

        // Corrupted redundancy field: three bad messages, then one good one.
        base_ack  = acked;
        base_d[0] = deliv[0];
        for (int b = 0; b < 3; b++) begin
            m = mk(40 + b, 5, b);
            m[b] = ~m[b];
            tx_q.push_back(m);
`ifndef ND_1TON_RED_CHECK_EN
            exp_q[0].push_back(m);
`endif
        end
        send(44, 5, 12, 0);
        drain("red", 600);
        check("red acks", 64'(acked - base_ack), 64'd4);
`ifdef ND_1TON_RED_CHECK_EN
        check("red delivered", 64'(deliv[0] - base_d[0]), 64'd1);
        check("red err_cnt",   64'(err_cnt),              64'd3);
`else
        check("red delivered", 64'(deliv[0] - base_d[0]), 64'd4);
        check("red err_cnt",   64'(err_cnt),              64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/nd_1ton_buf.md
Name: nd_1ton_buf

Overview:
- Parametrised successor to the 1-to-2 routing node. One receive channel fans out to NUM_OUT send channels.
- Routing is by destination-address comparison against an ascending list of thresholds, using greater-than semantics.
- Each output has its own FIFO, so a stalled sink does not block traffic to other sinks until that sink's FIFO is full.
- Sits between an io source and NUM_OUT sinks or downstream nodes in the message network.

Parameters:
- ASZ, 6: address field width (src and dst).
- DSZ, 4: data field width.
- RSZ, 4: redundancy field width.
- NUM_OUT, 4: number of send channels, 2..8.
- DEPTH, 4: entries per output FIFO; power of 2, at least 2.
- REF_VALS, {6'd41,6'd27,6'd13}: packed (NUM_OUT-1)*ASZ thresholds. Threshold k is REF_VALS[k*ASZ +: ASZ]. Must be strictly ascending.

Ports:
- i_clk  in  1  node clock.
- reset  in  1  asynchronous, active-low reset.
- ready  out  1  node operational.
- rcv0_req  in  1  input request.
- rcv0_dat  in  MSZ  input message. MSZ = 2*ASZ+DSZ+RSZ, packed {src,dst,dat,red}.
- rcv0_ack  out  1  input acknowledge.
- snd_req  out  NUM_OUT  per-output request; bit k is channel k.
- snd_dat  out  NUM_OUT*MSZ  per-output message; slice k*MSZ +: MSZ.
- snd_ack  in  NUM_OUT  per-output acknowledge.
- err_cnt  out  8  count of dropped messages (see Optional Feature).

Behaviour:
- Reset (reset=0, async):
  - all outputs 0: ready, rcv0_ack, snd_req, snd_dat, err_cnt.
  - FIFOs empty; both FSMs idle.
  - In-flight messages are lost.
  - Async assertion is allowed mid-handshake.
- ready rises on the first i_clk edge after reset deasserts and stays 1.
- Handshake on every channel is 4-phase:
  - sender holds dat stable with req=1;
  - receiver raises ack;
  - sender drops req;
  - receiver drops ack.
  - All handshake outputs are registered.
- Route index = number of k with dst > threshold k; range 0..NUM_OUT-1.
  - Example, default params: dst 13 -> 0; 14 -> 1; 27 -> 1; 28 -> 2; 41 -> 2; 42..63 -> 3.
- Input FSM:
  - RX_IDLE: if rcv0_req=1 and FIFO[idx] is not full, write the message, set rcv0_ack<=1, go to RX_ACK. If FIFO[idx] is full, hold rcv0_ack=0 (head-of-line stall) and stay.
  - RX_ACK: when rcv0_req=0, set rcv0_ack<=0 and go to RX_IDLE.
  - Latency: req sampled at edge t, ack high after edge t, FIFO count updated after edge t.
- Output FSM, per channel k:
  - TX_IDLE: if FIFO non-empty and snd_ack[k]=0, load the head into the snd_dat slice, set snd_req[k]<=1, go to TX_REQ.
  - TX_REQ: when snd_ack[k]=1, set snd_req[k]<=0, pop, go to TX_WAIT.
  - TX_WAIT: when snd_ack[k]=0, go to TX_IDLE.
  - snd_dat holds its last value while idle.
- Latency through an empty FIFO: input ack at t+1, output req at t+2.
- Simultaneous push and pop on the same FIFO in one cycle is supported.
  - Full is judged on the pre-edge count, so a full FIFO does not accept a write in its pop cycle.
  - No write-through.
- Message ordering is preserved per output. There is no ordering guarantee across outputs.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.
- err_cnt saturates at 255.

Optional Feature:
- Macro: ND_1TON_RED_CHECK_EN.
- Defined:
  - red is checked on accept. Rule: red[i] = XOR of every bit j of {src,dst,dat} with j mod RSZ == i.
  - On mismatch, the message is acked normally but not written to any FIFO, and err_cnt increments.
  - A full target FIFO is still evaluated first; bad messages stall like good ones.
- Undefined: no check is made, every message is routed, and err_cnt is constant 0.

Test Plan:
- Reset, then send dst=5, 20, 30, 50 (default params) -> one message each on snd channels 0, 1, 2, 3, with fields unchanged and order preserved.
- Send dst=13, 14, 27, 28, 41, 42 -> routed to channels 0, 1, 1, 2, 2, 3 respectively (boundary thresholds).
- Hold snd_ack[1]=0 and send 5 messages with dst=20 -> first 4 acked, 5th stalls with rcv0_ack=0. A dst=50 message behind it also waits. Release channel 1 -> all 6 delivered, channel 1 in FIFO order.
- Sinks ack on the same cycle req rises, with a continuous stream to channel 0 -> sustained push/pop, no loss or duplication across 20 messages, pointer wrap exercised.
- Assert reset while snd_req[2]=1 and the FIFO holds 3 entries -> all req/ack drop immediately. After release, ready returns on the next edge with empty FIFOs.
- With ND_1TON_RED_CHECK_EN, send 3 messages with one red bit flipped, then 1 good message -> 4 acks, only the good message delivered, err_cnt=3. Without the macro -> 4 delivered, err_cnt=0.
